game_timer: RTL and testbench

GAME_TIMER -- requirements
Module: game_timer

---
 rtl/game_timer.sv | 160 ++++++++++++++++
 tb/tb_game_timer.sv | 153 +++++++++++++++
 2 files changed

// File: rtl/game_timer.sv
// -----------------------------------------------------------------------------
// game_timer
//   Countdown game clock with pause, bonus time and a low-time warning.
//   Remaining time T is held in tenths of a second (0..999) and presented as
//   three registered BCD digits ss.t.
//
//   State | Meaning
//   ------+-------------------------------------------------------------
//   IDLE  | waiting for start, T held at START_SEC*10
//   RUN   | counting down one tenth per tick
//   PAUSE | countdown frozen, bonus time still accepted
//   DONE  | time expired, T held at 0 until start
//
// Ports
//   clk       in   system clock, rising edge
//   rst_n     in   asynchronous active-low reset
//   tick      in   100 ms pulse from upstream tick generator
//   start     in   begin / resume / restart pulse
//   pause     in   run/pause toggle pulse
//   add_time  in   add BONUS_SEC seconds pulse
//   sec_tens  out  BCD tens of seconds
//   sec_ones  out  BCD seconds
//   tenths    out  BCD tenths of a second
//   running   out  high while in RUN
//   time_up   out  high while in DONE
//   expire    out  one-cycle pulse after entering DONE
//   warn      out  RUN/PAUSE with 0 < T < WARN_SEC*10
// -----------------------------------------------------------------------------
module game_timer #(
    parameter int START_SEC = 60,
    parameter int BONUS_SEC = 5,
    parameter int WARN_SEC  = 10
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       tick,
    input  logic       start,
    input  logic       pause,
    input  logic       add_time,
    output logic [3:0] sec_tens,
    output logic [3:0] sec_ones,
    output logic [3:0] tenths,
    output logic       running,
    output logic       time_up,
    output logic       expire,
    output logic       warn
);

    localparam logic [9:0]  START_T = 10'(START_SEC * 10);
    localparam logic [10:0] BONUS_T = 11'(BONUS_SEC * 10);
    localparam logic [9:0]  WARN_T  = 10'(WARN_SEC * 10);
    localparam logic [9:0]  MAX_T   = 10'd999;

    localparam logic [3:0]  START_TENS = 4'(START_SEC / 10);
    localparam logic [3:0]  START_ONES = 4'(START_SEC % 10);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t      state, nxt_state;
    logic [9:0]  t, nxt_t;
    logic        nxt_expire;
    logic [9:0]  t_base;
    logic [10:0] t_sum;
    logic [9:0]  t_bonus;

    // Tick only counts in RUN; clamping at 0 keeps T from wrapping.
    always_comb begin
        t_base  = t;
        if (state == RUN && tick && t != 10'd0) begin
            t_base = t - 10'd1;
        end
        t_sum   = {1'b0, t_base} + BONUS_T;
        t_bonus = (t_sum > {1'b0, MAX_T}) ? MAX_T : t_sum[9:0];
    end

    always_comb begin
        nxt_state  = state;
        nxt_t      = t;
        nxt_expire = 1'b0;
        case (state)
            IDLE: begin
                nxt_t = START_T;
                if (start) begin
                    nxt_state = RUN;
                end
            end
            RUN: begin
                if (start) begin
                    nxt_t = START_T;
                end else begin
                    nxt_t = add_time ? t_bonus : t_base;
                    // Expiry outranks a coincident pause.
                    if (!add_time && t_base == 10'd0) begin
                        nxt_state  = DONE;
                        nxt_expire = 1'b1;
                    end else if (pause) begin
                        nxt_state = PAUSE;
                    end
                end
            end
            PAUSE: begin
                if (start || pause) begin
                    nxt_state = RUN;
                end else if (add_time) begin
                    nxt_t = t_bonus;
                end
            end
            DONE: begin
                nxt_t = 10'd0;
                if (start) begin
                    nxt_state = RUN;
                    nxt_t     = START_T;
                end
            end
            default: begin
                nxt_state = IDLE;
                nxt_t     = START_T;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            t     <= START_T;
        end else begin
            state <= nxt_state;
            t     <= nxt_t;
        end
    end

    // Outputs are registered from the next-state values so they change on the
    // same edge as state and T.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sec_tens <= START_TENS;
            sec_ones <= START_ONES;
            tenths   <= 4'd0;
            running  <= 1'b0;
            time_up  <= 1'b0;
            expire   <= 1'b0;
            warn     <= 1'b0;
        end else begin
            sec_tens <= 4'(nxt_t / 10'd100);
            sec_ones <= 4'((nxt_t / 10'd10) % 10'd10);
            tenths   <= 4'(nxt_t % 10'd10);
            running  <= (nxt_state == RUN);
            time_up  <= (nxt_state == DONE);
            expire   <= nxt_expire;
            warn     <= ((nxt_state == RUN) || (nxt_state == PAUSE)) &&
                        (nxt_t < WARN_T) && (nxt_t != 10'd0);
        end
    end

endmodule

// File: tb/tb_game_timer.sv
module tb_game_timer;

    logic       clk;
    logic       rst_n;
    logic       tick;
    logic       start;
    logic       pause;
    logic       add_time;
    logic [3:0] sec_tens;
    logic [3:0] sec_ones;
    logic [3:0] tenths;
    logic       running;
    logic       time_up;
    logic       expire;
    logic       warn;

    game_timer dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .tick     (tick),
        .start    (start),
        .pause    (pause),
        .add_time (add_time),
        .sec_tens (sec_tens),
        .sec_ones (sec_ones),
        .tenths   (tenths),
        .running  (running),
        .time_up  (time_up),
        .expire   (expire),
        .warn     (warn)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       tag;
        logic [15:0] val;   // {tens, ones, tenths, running, time_up, warn, expire}
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    // Expected display time given in tenths of a second.
    task automatic push(input string tag, input int tt, input logic r,
                        input logic tu, input logic w, input logic e);
        exp_t x;
        x.tag = tag;
        x.val = {4'(tt / 100), 4'((tt / 10) % 10), 4'(tt % 10), r, tu, w, e};
        exp_q.push_back(x);
    endtask

    task automatic check();
        exp_t        x;
        logic [15:0] obs;
        x   = exp_q.pop_front();
        obs = {sec_tens, sec_ones, tenths, running, time_up, warn, expire};
        checks++;
        assert (obs === x.val) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", x.tag, obs, x.val);
        end
    endtask

    task automatic step(input logic s, input logic p, input logic t, input logic a);
        @(negedge clk);
        start    = s;
        pause    = p;
        tick     = t;
        add_time = a;
        @(posedge clk);
        #1;
        start    = 1'b0;
        pause    = 1'b0;
        tick     = 1'b0;
        add_time = 1'b0;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 1, 0);
    endtask

    initial begin
        rst_n = 1'b0; tick = 1'b0; start = 1'b0; pause = 1'b0; add_time = 1'b0;
        #23;
        push("reset", 600, 0, 0, 0, 0); check();
        @(negedge clk); rst_n = 1'b1;

        push("idle_ignores", 600, 0, 0, 0, 0); step(0, 1, 1, 1); check();
        push("start", 600, 1, 0, 0, 0);        step(1, 0, 0, 0); check();
        ticks(14);
        push("15_ticks", 585, 1, 0, 0, 0);     step(0, 0, 1, 0); check();

        ticks(484);
        push("at_10_0", 100, 1, 0, 0, 0);      step(0, 0, 1, 0); check();
        push("warn_9_9", 99, 1, 0, 1, 0);      step(0, 0, 1, 0); check();
        push("pause", 99, 0, 0, 1, 0);         step(0, 1, 0, 0); check();
        ticks(4);
        push("paused_ticks", 99, 0, 0, 1, 0);  step(0, 0, 1, 0); check();
        push("resume", 99, 1, 0, 1, 0);        step(0, 1, 0, 0); check();
        push("resume_tick", 98, 1, 0, 1, 0);   step(0, 0, 1, 0); check();
        push("add_run", 148, 1, 0, 0, 0);      step(0, 0, 0, 1); check();

        ticks(144);
        push("at_0_3", 3, 1, 0, 1, 0);         step(0, 0, 1, 0); check();
        push("at_0_2", 2, 1, 0, 1, 0);         step(0, 0, 1, 0); check();
        push("at_0_1", 1, 1, 0, 1, 0);         step(0, 0, 1, 0); check();
        push("expire", 0, 0, 1, 0, 1);         step(0, 0, 1, 0); check();
        push("expire_1cyc", 0, 0, 1, 0, 0);    step(0, 0, 0, 0); check();
        push("done_tick", 0, 0, 1, 0, 0);      step(0, 0, 1, 0); check();
        push("done_add", 0, 0, 1, 0, 0);       step(0, 0, 0, 1); check();
        push("done_pause", 0, 0, 1, 0, 0);     step(0, 1, 0, 0); check();
        push("done_start", 600, 1, 0, 0, 0);   step(1, 0, 0, 0); check();

        for (int i = 0; i < 6; i++) step(0, 0, 0, 1);
        push("add_95_0", 950, 1, 0, 0, 0);     step(0, 0, 0, 1); check();
        push("add_sat", 999, 1, 0, 0, 0);      step(0, 0, 0, 1); check();
        ticks(28);
        push("at_97_0", 970, 1, 0, 0, 0);      step(0, 0, 1, 0); check();
        push("tick_add_sat", 999, 1, 0, 0, 0); step(0, 0, 1, 1); check();
        push("add_sat2", 999, 1, 0, 0, 0);     step(0, 0, 0, 1); check();

        push("run_restart", 600, 1, 0, 0, 0);  step(1, 0, 0, 0); check();
        ticks(598);
        push("at_0_1b", 1, 1, 0, 1, 0);        step(0, 0, 1, 0); check();
        push("tick_add_save", 50, 1, 0, 1, 0); step(0, 0, 1, 1); check();
        ticks(48);
        push("at_0_1c", 1, 1, 0, 1, 0);        step(0, 0, 1, 0); check();
        push("tick_pause_exp", 0, 0, 1, 0, 1); step(0, 1, 1, 0); check();

        push("restart2", 600, 1, 0, 0, 0);     step(1, 0, 0, 0); check();
        push("start_over_pause", 600, 1, 0, 0, 0); step(1, 1, 0, 0); check();
        push("pause_with_tick", 599, 0, 0, 0, 0);  step(0, 1, 1, 0); check();
        push("start_resume", 599, 1, 0, 0, 0);     step(1, 0, 0, 0); check();
        ticks(171);
        push("at_42_7", 427, 1, 0, 0, 0);      step(0, 0, 1, 0); check();

        @(negedge clk); #2;
        rst_n = 1'b0;
        #1;
        push("async_reset", 600, 0, 0, 0, 0);  check();
        @(negedge clk); #1;
        rst_n = 1'b1;
        push("post_rst_tick", 600, 0, 0, 0, 0); step(0, 0, 1, 0); check();
        push("post_rst_start", 600, 1, 0, 0, 0); step(1, 0, 0, 0); check();
        push("post_rst_run", 599, 1, 0, 0, 0); step(0, 0, 1, 0); check();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
